// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM state codes, default frame
// geometry and the counter width helper.
package lab_spi_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_CS_GAP     = 2;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin selector: first set request searching upward
// from the pointer, wrapping around NUM_REQ.
module rr_priority_pick
  import lab_spi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = cnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [IW-1:0]      o_idx
);

  int w_cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    w_cand = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_cand = int'(i_ptr) + off;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      if (i_req[IW'(w_cand)]) begin
        o_pick             = '0;
        o_pick[IW'(w_cand)] = 1'b1;
        o_idx              = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin SPI frame arbiter: grants one requester at a time, shifts a full
// MSB-first frame on the shared MOSI/MISO pair, then holds all chip selects high.
module spi_bus_arbiter
  import lab_spi_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CS_GAP     = DEF_CS_GAP
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FRAME_BITS-1:0] tx_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [FRAME_BITS-1:0]         rx_data,
  output logic                          busy,
  output logic [NUM_REQ-1:0]            cs_n,
  output logic                          mosi,
  input  logic                          miso
);

  localparam int IW = cnt_width(NUM_REQ);
  localparam int BW = cnt_width(FRAME_BITS);
  localparam int GW = cnt_width(CS_GAP);

  logic [1:0]            r_state;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_idx;
  logic [FRAME_BITS-1:0] r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic [GW-1:0]         r_gap_cnt;
  logic [FRAME_BITS-1:0] r_rx_data;

  logic [FRAME_BITS-1:0] w_tx_words [NUM_REQ];
  logic [NUM_REQ-1:0]    w_pick;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_in_frame;
  logic                  w_first_gap;
  logic [IW-1:0]         w_ptr_next;
  logic [FRAME_BITS-1:0] w_shift_next;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx)
  );

  assign w_in_frame   = (r_state == SETUP) || (r_state == SHIFT);
  assign w_first_gap  = (r_state == GAP) && (r_gap_cnt == '0);
  assign w_ptr_next   = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
  assign w_shift_next = {r_shift[FRAME_BITS-2:0], miso};

  // Outputs decode straight from state so the async reset clears them at once.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_tx_words[gi] = tx_data[gi*FRAME_BITS +: FRAME_BITS];
      assign grant[gi]      = (r_state == SETUP) && (r_idx == IW'(gi));
      assign done[gi]       = w_first_gap && (r_idx == IW'(gi));
      assign cs_n[gi]       = !(w_in_frame && (r_idx == IW'(gi)));
    end
  endgenerate

  assign mosi    = w_in_frame ? r_shift[FRAME_BITS-1] : 1'b0;
  assign busy    = (r_state != IDLE);
  assign rx_data = r_rx_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_rx_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick != '0) begin
            r_shift <= w_tx_words[w_pick_idx];
            r_idx   <= w_pick_idx;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_ptr     <= w_ptr_next;
          r_bit_cnt <= BW'(FRAME_BITS - 1);
          r_state   <= SHIFT;
        end
        SHIFT: begin
          r_shift <= w_shift_next;
          if (r_bit_cnt == '0) begin
            r_rx_data <= w_shift_next;
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end
        GAP: begin
          if (r_gap_cnt == GW'(CS_GAP - 1)) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: default build plus a CS_GAP=4 build.
module tb_spi_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] tx_data;
    logic [1:0]  grant, done, cs_n;
    logic [15:0] rx_data;
    logic        busy, mosi, miso;
    logic        lb;
    logic        miso_k;

    logic [1:0]  req2;
    logic [31:0] tx2;
    logic [1:0]  grant2, done2, cs_n2;
    logic [15:0] rx2;
    logic        busy2, mosi2, miso2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int both_low = 0;
    int overlap  = 0;
    int done_cnt = 0;

    assign miso  = lb ? mosi : miso_k;
    assign miso2 = mosi2;

    spi_bus_arbiter u_dut (
        .clk(clk), .reset(reset), .req(req), .tx_data(tx_data),
        .grant(grant), .done(done), .rx_data(rx_data), .busy(busy),
        .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_bus_arbiter #(.CS_GAP(4)) u_dut_gap (
        .clk(clk), .reset(reset), .req(req2), .tx_data(tx2),
        .grant(grant2), .done(done2), .rx_data(rx2), .busy(busy2),
        .cs_n(cs_n2), .mosi(mosi2), .miso(miso2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (cs_n == 2'b00) both_low++;
            if (grant != 2'b00 && done != 2'b00) overlap++;
            if (done != 2'b00) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end else begin
            $display("PASS %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_grant(output logic [1:0] g, output int idle, output bit ok);
        g = 2'b00; idle = 0; ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (grant != 2'b00) begin
                g = grant; ok = 1'b1;
                break;
            end
            if (!busy) idle++;
        end
    endtask

    task automatic wait_done(output logic [1:0] d, output bit ok);
        d = 2'b00; ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (done != 2'b00) begin
                d = done; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic [1:0]  g, d;
        logic [15:0] w;
        int          idle, g0, low_cnt, gap, idl, dsnap;
        bit          ok, seen1;

        reset = 1'b1; req = 2'b00; tx_data = '0; lb = 1'b1; miso_k = 1'b0;
        req2 = 2'b00; tx2 = '0;
        repeat (3) tick();

        check("rst_cs_n", cs_n, 2'b11);
        check("rst_mosi", mosi, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_rx", rx_data, 16'h0000);
        reset = 1'b0;
        tick();

        tx_data = {16'h0000, 16'hA5C3};
        req = 2'b01;
        tick();
        check("sf_grant", grant, 2'b01);
        check("sf_setup_mosi", mosi, 1'b1);
        check("sf_busy", busy, 1'b1);
        req = 2'b00;
        low_cnt = (cs_n == 2'b10) ? 1 : 0;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            tick();
            w = {w[14:0], mosi};
            if (cs_n == 2'b10) low_cnt++;
        end
        check("sf_mosi_bits", w, 16'hA5C3);
        check("sf_cs_low_cycles", low_cnt, 17);
        tick();
        check("sf_done", done, 2'b01);
        check("sf_rx", rx_data, 16'hA5C3);
        check("sf_gap_cs_n", cs_n, 2'b11);
        check("sf_gap_mosi", mosi, 1'b0);
        tick();
        check("sf_gap2_done", done, 2'b00);
        check("sf_gap2_busy", busy, 1'b1);
        tick();
        check("sf_idle_busy", busy, 1'b0);

        reset = 1'b1; tick(); reset = 1'b0;
        lb = 1'b0; miso_k = 1'b1;
        tx_data = {16'hBEEF, 16'h1234};
        req = 2'b11;
        tick();
        check("sim_first_grant", grant, 2'b01);
        check("sim_first_mosi", mosi, 1'b0);
        g0 = cyc;
        req = 2'b10;
        wait_grant(g, idle, ok);
        check("sim_grant_seen", ok, 1'b1);
        check("sim_second_grant", g, 2'b10);
        check("sim_grant_spacing", cyc - g0, 20);
        check("sim_second_mosi", mosi, 1'b1);
        req = 2'b00;
        wait_done(d, ok);
        check("sim_done_seen", ok, 1'b1);
        check("sim_done", d, 2'b10);
        check("sim_rx", rx_data, 16'hFFFF);

        wait_idle(ok);
        check("fair_idle_start", ok, 1'b1);
        req = 2'b11;
        for (int f = 0; f < 6; f++) begin
            wait_grant(g, idle, ok);
            check("fair_grant_seen", ok, 1'b1);
            check("fair_grant", g, (f % 2 == 0) ? 2'b01 : 2'b10);
            if (f > 0) check("fair_idle_cycles", idle, 1);
        end
        req = 2'b00;
        wait_idle(ok);
        check("fair_idle_end", ok, 1'b1);

        lb = 1'b1;
        tx_data = {16'h0000, 16'h3C96};
        req = 2'b01;
        tick();
        check("wd_grant0", grant, 2'b01);
        req = 2'b00;
        seen1 = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (n == 4) req = 2'b10;
            if (n == 7) req = 2'b00;
            if (grant[1] || !cs_n[1]) seen1 = 1'b1;
        end
        check("wd_no_req1_activity", seen1, 1'b0);
        check("wd_busy_dropped", busy, 1'b0);
        check("wd_rx", rx_data, 16'h3C96);

        tx_data = {16'h5A5A, 16'hFFFF};
        req = 2'b01;
        tick();
        check("rm_grant0", grant, 2'b01);
        req = 2'b00;
        repeat (9) tick();
        check("rm_pre_cs_n", cs_n, 2'b10);
        check("rm_pre_mosi", mosi, 1'b1);
        dsnap = done_cnt;
        reset = 1'b1;
        #1;
        check("rm_async_cs_n", cs_n, 2'b11);
        check("rm_async_mosi", mosi, 1'b0);
        check("rm_async_busy", busy, 1'b0);
        tick();
        check("rm_no_done", done, 2'b00);
        reset = 1'b0;
        req = 2'b10;
        tick();
        check("rm_grant1", grant, 2'b10);
        check("rm_done_count", done_cnt, dsnap);
        req = 2'b00;
        wait_done(d, ok);
        check("rm_done_seen", ok, 1'b1);
        check("rm_done1", d, 2'b10);
        check("rm_rx", rx_data, 16'h5A5A);

        tx2 = {16'h0000, 16'hC0DE};
        req2 = 2'b01;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (grant2 != 2'b00) begin ok = 1'b1; break; end
        end
        check("gap_first_grant_seen", ok, 1'b1);
        check("gap_first_grant", grant2, 2'b01);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (cs_n2 == 2'b11) begin ok = 1'b1; break; end
        end
        check("gap_frame_end_seen", ok, 1'b1);
        check("gap_done", done2, 2'b01);
        check("gap_rx", rx2, 16'hC0DE);
        gap = 0; idl = 0;
        for (int n = 0; n < 20 && busy2 && cs_n2 == 2'b11; n++) begin
            gap++;
            tick();
        end
        for (int n = 0; n < 20 && !busy2; n++) begin
            idl++;
            tick();
        end
        check("gap_high_cycles", gap, 4);
        check("gap_idle_cycles", idl, 1);
        check("gap_second_grant", grant2, 2'b01);
        req2 = 2'b00;

        check("inv_cs_both_low", both_low, 0);
        check("inv_grant_done_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Round-robin scheduler that shares one serial data path (shared MOSI/MISO, shared sclk-domain timing) between NUM_REQ SPI requesters, e.g. the ADC sampler and the DAC writer on the GPIO0 header.
- Serializes whole frames: grants one requester, drives its chip-select low, shifts FRAME_BITS bits out and in, then enforces an inter-frame CS gap.
- Runs entirely on the SPI clock net.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- FRAME_BITS, 16, bits per transaction, MSB first.
- CS_GAP, 2, minimum cycles with all cs_n high between frames (>=1).

Ports:
- clk  in  1  SPI bit clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until granted.
- tx_data  in  NUM_REQ*FRAME_BITS  per-requester outbound word; requester i uses slice [i*FRAME_BITS +: FRAME_BITS]; sampled on the grant edge.
- grant  out  NUM_REQ  one-hot, one-cycle pulse marking acceptance of a request.
- done  out  NUM_REQ  one-hot, one-cycle pulse at frame completion.
- rx_data  out  FRAME_BITS  word captured from miso during the last completed frame.
- busy  out  1  high whenever state != IDLE.
- cs_n  out  NUM_REQ  per-requester chip select, active low.
- mosi  out  1  shared serial data out.
- miso  in  1  shared serial data in.

Behaviour:
- Reset (async, immediate):
  - cs_n all ones; mosi=0; grant=0; done=0; busy=0; rx_data=0.
  - Round-robin pointer=0 (requester 0 has highest priority first); state=IDLE.
  - Reset mid-frame aborts the frame. No done is issued and the aborted requester's pending req is not remembered.
- FSM states: IDLE, SETUP, SHIFT, GAP.
- IDLE:
  - On an edge with any req bit high, pick the first set bit searching upward from pointer, wrapping modulo NUM_REQ.
  - On that edge: latch that requester's tx_data into the shift register, record the index, go to SETUP.
  - With no req high, stay in IDLE.
- SETUP (1 cycle):
  - grant[idx]=1 this cycle only; cs_n[idx]=0; mosi=tx bit FRAME_BITS-1.
  - Pointer updates to idx+1 mod NUM_REQ.
  - Bit counter loads FRAME_BITS-1.
- SHIFT (FRAME_BITS cycles):
  - cs_n[idx]=0; mosi=shift-register MSB.
  - At the end of each cycle, miso shifts into the LSB and the register shifts left, so cycle k drives bit FRAME_BITS-1-k.
  - The counter decrements; the cycle where the counter is 0 is the last one, and the next state is GAP.
- GAP (CS_GAP cycles):
  - All cs_n high; mosi=0.
  - First GAP cycle: done[idx]=1 and rx_data updated to the captured word. rx_data then holds until the next done.
  - After CS_GAP cycles, return to IDLE.
- Frame timing: cs_n is low for exactly FRAME_BITS+1 cycles.
- Worst-case latency, req to grant: 1 cycle (IDLE edge) plus up to (NUM_REQ-1)*(FRAME_BITS+2+CS_GAP) cycles of other frames.
- Request handling:
  - A req that drops before its grant is ignored; no transaction occurs.
  - req changes during a frame have no effect until IDLE.
  - tx_data changes after the grant edge have no effect on the current frame.
- Simultaneous requests: only one grant per IDLE visit; the other requester is served next because the pointer rotates. No starvation.
- Back-to-back: a requester holding req continuously after its grant gets its next frame only after every other pending requester.
- Invariants: at most one cs_n low at any time; grant and done are never both nonzero in the same cycle.

Decomposition:
- Shared package lab_spi_pkg holds:
  - state encoding constants (IDLE=2'd0, SETUP=2'd1, SHIFT=2'd2, GAP=2'd3);
  - default FRAME_BITS, CS_GAP;
  - the clog2-based counter width helper.
- One natural sub-module, rr_priority_pick: combinational round-robin selector (req, pointer -> one-hot pick plus index). The FSM and shifter stay in the top.

Test Plan:
- Single frame: req=2'b01, tx_data[15:0]=16'hA5C3, miso looped to mosi → grant[0] 1 cycle after req edge; cs_n[0] low 17 cycles; mosi bits 1010010111000011; done[0] in first GAP cycle; rx_data=16'hA5C3.
- Simultaneous requests after reset: req=2'b11, tx0=16'h1234, tx1=16'hBEEF → requester 0 frame first, then requester 1. Second grant 2+16+2=20 cycles after the first. cs_n never both low. Final rx_data equals miso pattern driven by bench (constant 1 → 16'hFFFF).
- Fairness: req held at 2'b11 for 6 frames → grant sequence 0,1,0,1,0,1; busy stays high except 1 IDLE cycle between frames.
- Withdrawn request: req[1] pulsed high for 3 cycles while frame 0 is in SHIFT → no grant[1], no cs_n[1] activity, busy drops after GAP.
- Reset mid-frame: assert reset at SHIFT bit 7 → cs_n=2'b11 and mosi=0 within the same cycle (async); no done pulse; after release with req=2'b10, requester 1 is granted immediately (pointer=0 but req[0] low).
- Gap enforcement, CS_GAP=4 build: back-to-back req on requester 0 → exactly 4 all-high cs_n cycles plus 1 IDLE cycle between frames.
